// File: rtl/rdout_framer.sv
// rtl/rdout_framer.sv - readout framer: 32x17 FIFO with trailer insertion, hold register and overflow tracking
module rdout_framer #(
  parameter int TMR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        lastword,
  input  logic        errload,
  input  logic        rd_en,
  output logic [15:0] dout,
  output logic        dvalid,
  output logic        empty,
  output logic        afull,
  output logic [3:0]  nframes,
  output logic        frame_rdy,
  output logic        ovfl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    TRLR = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // bit 16 tags a trailer word
  logic [16:0] mem [32];
  logic [5:0]  wptr;
  logic [5:0]  rptr;
  logic [5:0]  wptr_next;
  logic [5:0]  rptr_next;
  logic [5:0]  count_next;

  logic        hold_v;
  logic [15:0] hold_d;
  logic        hold_last;
  logic        hold_err;

  logic [7:0]  wc;
  logic        errflag;
  logic        ovflag;

  logic        acc_valid;
  logic [15:0] acc_data;
  logic        acc_last;
  logic        acc_err;
  logic        trlr_wr;
  logic        data_wr;
  logic        drop_acc;
  logic        drop_push;
  logic        hold_load;
  logic        hold_clear;
  logic        wr_en;
  logic [16:0] wr_word;
  logic        rd_ok;
  logic        pop_trlr;
  logic [3:0]  nframes_next;

  // Word selection, FIFO bookkeeping and next-state decode
  always_comb begin
    acc_valid    = 1'b0;
    acc_data     = din;
    acc_last     = lastword;
    acc_err      = errload;
    trlr_wr      = 1'b0;
    data_wr      = 1'b0;
    drop_acc     = 1'b0;
    drop_push    = 1'b0;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    wr_en        = 1'b0;
    wr_word      = 17'h0;
    rd_ok        = 1'b0;
    pop_trlr     = 1'b0;
    wptr_next    = wptr;
    rptr_next    = rptr;
    count_next   = 6'd0;
    nframes_next = nframes;
    state_next   = state;

    trlr_wr = (state == TRLR);

    // A parked word always goes ahead of the live input so word order is kept
    if (hold_v) begin
      acc_data = hold_d;
      acc_last = hold_last;
      acc_err  = hold_err;
    end
    acc_valid = !trlr_wr && (hold_v || push);

    // Data writes are blocked once 31 words are held, which leaves the last slot for the trailer
    data_wr  = acc_valid && !afull;
    drop_acc = acc_valid && afull;

    // In TRLR a push parks in hold; while hold drains, a live push takes its place
    drop_push  = push && trlr_wr && hold_v;
    hold_load  = push && (trlr_wr ? !hold_v : hold_v);
    hold_clear = !trlr_wr && hold_v && !push;

    wr_en   = data_wr || trlr_wr;
    wr_word = trlr_wr ? {1'b1, 4'hE, errflag, ovflag, 2'b00, wc} : {1'b0, acc_data};

    rd_ok    = rd_en && !empty;
    pop_trlr = rd_ok && mem[rptr[4:0]][16];

    wptr_next    = wptr + {5'd0, wr_en};
    rptr_next    = rptr + {5'd0, rd_ok};
    // Wrapping 6-bit pointers give occupancy 0..32 directly
    count_next   = wptr_next - rptr_next;
    nframes_next = nframes + {3'd0, trlr_wr} - {3'd0, pop_trlr};

    case (state)
      IDLE:    if (acc_valid) state_next = acc_last ? TRLR : BODY;
      BODY:    if (acc_valid && acc_last) state_next = TRLR;
      TRLR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    if (TMR != 0) begin : g_tmr
      state_t st_a;
      state_t st_b;
      state_t st_c;

      // Three copies of the state register, majority-voted bit by bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_a <= IDLE;
          st_b <= IDLE;
          st_c <= IDLE;
        end else begin
          st_a <= state_next;
          st_b <= state_next;
          st_c <= state_next;
        end
      end

      assign state = state_t'((st_a & st_b) | (st_a & st_c) | (st_b & st_c));
    end else begin : g_single
      // Plain state register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
      end
    end
  endgenerate

  // Storage array; contents are abandoned on reset by clearing the pointers
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[4:0]] <= wr_word;
  end

  // Pointers, read port, status flags, hold register and per-frame accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= 6'd0;
      rptr      <= 6'd0;
      dout      <= 16'h0000;
      dvalid    <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      nframes   <= 4'd0;
      frame_rdy <= 1'b0;
      ovfl      <= 1'b0;
      hold_v    <= 1'b0;
      hold_d    <= 16'h0000;
      hold_last <= 1'b0;
      hold_err  <= 1'b0;
      wc        <= 8'd0;
      errflag   <= 1'b0;
      ovflag    <= 1'b0;
    end else begin
      wptr      <= wptr_next;
      rptr      <= rptr_next;
      dvalid    <= rd_ok;
      if (rd_ok) dout <= mem[rptr[4:0]][15:0];
      empty     <= (count_next == 6'd0);
      afull     <= (count_next >= 6'd31);
      nframes   <= nframes_next;
      frame_rdy <= (nframes_next != 4'd0);
      if (drop_acc || drop_push) ovfl <= 1'b1;

      if (hold_load) begin
        hold_v    <= 1'b1;
        hold_d    <= din;
        hold_last <= lastword;
        hold_err  <= errload;
      end else if (hold_clear) begin
        hold_v    <= 1'b0;
      end

      if (trlr_wr) begin
        wc      <= 8'd0;
        errflag <= 1'b0;
        ovflag  <= 1'b0;
      end else begin
        if (data_wr && (wc != 8'hFF)) wc <= wc + 8'd1;
        if (acc_valid && acc_err)     errflag <= 1'b1;
        if (drop_acc)                 ovflag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rdout_framer.sv
// tb/tb_rdout_framer.sv - directed self-checking bench for rdout_framer
module tb_rdout_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic [15:0] din = 16'h0;
  logic        lastword = 1'b0;
  logic        errload = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] dout;
  logic        dvalid;
  logic        empty;
  logic        afull;
  logic [3:0]  nframes;
  logic        frame_rdy;
  logic        ovfl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rdout_framer #(.TMR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (din),
    .lastword  (lastword),
    .errload   (errload),
    .rd_en     (rd_en),
    .dout      (dout),
    .dvalid    (dvalid),
    .empty     (empty),
    .afull     (afull),
    .nframes   (nframes),
    .frame_rdy (frame_rdy),
    .ovfl      (ovfl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge
  task automatic step(input logic p, input logic [15:0] d, input logic l, input logic e, input logic r);
    push = p; din = d; lastword = l; errload = e; rd_en = r;
    @(posedge clk);
    #1;
    push = 1'b0; din = 16'h0; lastword = 1'b0; errload = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check({tag, "_dvalid"}, {31'd0, dvalid}, 32'd1);
    check(tag, {16'd0, dout}, {16'd0, exp});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dout"},      {16'd0, dout},      32'h0);
    check({tag, "_dvalid"},    {31'd0, dvalid},    32'd0);
    check({tag, "_empty"},     {31'd0, empty},     32'd1);
    check({tag, "_afull"},     {31'd0, afull},     32'd0);
    check({tag, "_nframes"},   {28'd0, nframes},   32'd0);
    check({tag, "_frame_rdy"}, {31'd0, frame_rdy}, 32'd0);
    check({tag, "_ovfl"},      {31'd0, ovfl},      32'd0);
  endtask

  initial begin
    logic [15:0] expq [18];
    int idx;

    // Reset state
    #2 rst = 1'b1;
    #1 check_reset_state("rst0");
    @(posedge clk); #1 rst = 1'b0;

    // Three-word frame
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("first_push_empty", {31'd0, empty}, 32'd0);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    check("f1_nframes_pre", {28'd0, nframes}, 32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("f1_nframes", {28'd0, nframes}, 32'd1);
    check("f1_frame_rdy", {31'd0, frame_rdy}, 32'd1);
    pop_expect("f1_w0", 16'h0001);
    pop_expect("f1_w1", 16'h0002);
    pop_expect("f1_w2", 16'h0003);
    pop_expect("f1_trl", 16'hE003);
    check("f1_empty", {31'd0, empty}, 32'd1);
    check("f1_nframes_after", {28'd0, nframes}, 32'd0);
    check("f1_frame_rdy_after", {31'd0, frame_rdy}, 32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("pop_empty_dvalid", {31'd0, dvalid}, 32'd0);
    check("pop_empty_hold", {16'd0, dout}, 32'hE003);

    // Error-flagged two-word frame
    step(1'b1, 16'h000A, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h000B, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("f2_nframes", {28'd0, nframes}, 32'd1);
    pop_expect("f2_w0", 16'h000A);
    pop_expect("f2_w1", 16'h000B);
    pop_expect("f2_trl", 16'hE802);
    check("f2_nframes_after", {28'd0, nframes}, 32'd0);
    check("f2_empty", {31'd0, empty}, 32'd1);

    // Push during the trailer cycle goes through hold
    step(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0066, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("hold_ovfl", {31'd0, ovfl}, 32'd0);
    check("hold_nframes", {28'd0, nframes}, 32'd2);
    pop_expect("hold_w0", 16'h0011);
    pop_expect("hold_trl0", 16'hE001);
    pop_expect("hold_w1", 16'h0055);
    pop_expect("hold_w2", 16'h0066);
    pop_expect("hold_trl1", 16'hE002);
    check("hold_empty", {31'd0, empty}, 32'd1);

    // Streaming: push and pop every cycle, two 8-word frames
    for (int i = 0; i < 8; i++) expq[i] = 16'(i + 1);
    expq[8] = 16'hE008;
    for (int i = 0; i < 8; i++) expq[9 + i] = 16'(i + 9);
    expq[17] = 16'hE008;
    idx = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 16) step(1'b1, 16'(c), (c == 8) || (c == 16), 1'b0, 1'b1);
      else         step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (dvalid) begin
        if (idx < 18) check("stream_word", {16'd0, dout}, {16'd0, expq[idx]});
        else          check("stream_extra", {31'd0, dvalid}, 32'd0);
        idx++;
      end
      if (c == 19) check("stream_drained", {31'd0, empty}, 32'd1);
    end
    check("stream_len", idx, 18);
    check("stream_ovfl", {31'd0, ovfl}, 32'd0);

    // Overflow: 35 pushes, no reads
    for (int i = 1; i <= 35; i++) step(1'b1, 16'(i), i == 35, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("ov_afull", {31'd0, afull}, 32'd1);
    check("ov_ovfl", {31'd0, ovfl}, 32'd1);
    check("ov_nframes", {28'd0, nframes}, 32'd1);
    for (int i = 0; i < 32; i++) pop_expect("ov_word", (i < 31) ? 16'(i + 1) : 16'hE41F);
    check("ov_empty", {31'd0, empty}, 32'd1);
    check("ov_afull_after", {31'd0, afull}, 32'd0);
    check("ov_ovfl_sticky", {31'd0, ovfl}, 32'd1);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    check("mid_not_empty", {31'd0, empty}, 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_state("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    step(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("post_rst_nframes", {28'd0, nframes}, 32'd1);
    pop_expect("post_rst_w0", 16'h0007);
    pop_expect("post_rst_w1", 16'h0008);
    pop_expect("post_rst_trl", 16'hE002);
    check("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rdout_framer.md
RDOUT_FRAMER -- requirements
Module: rdout_framer

Interface
REQ-001 Parameter TMR, default 0: triplication select; SHALL have no effect on cycle behaviour.
REQ-002 CLK  in  1  single clock for all logic; rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 PUSH  in  1  data word valid from readout control; one word per cycle.
REQ-005 DIN  in  16  data word captured with PUSH.
REQ-006 LASTWORD  in  1  qualifies PUSH word as final word of frame.
REQ-007 ERRLOAD  in  1  qualifies PUSH word as carrying an error condition.
REQ-008 RD_EN  in  1  downstream pop request.
REQ-009 DOUT  out  16  registered FIFO read data.
REQ-010 DVALID  out  1  DOUT valid, one cycle per accepted pop.
REQ-011 EMPTY  out  1  FIFO holds 0 words.
REQ-012 AFULL  out  1  FIFO holds >=31 words; data writes blocked.
REQ-013 NFRAMES  out  4  complete frames (trailers) held in FIFO.
REQ-014 FRAME_RDY  out  1  NFRAMES != 0.
REQ-015 OVFL  out  1  sticky: any data word dropped.

Function
REQ-016 Storage SHALL be 32 x 17 bits (16 data + trailer tag), 6-bit wrapping read/write pointers, 6-bit occupancy count 0..32.
REQ-017 FSM states SHALL be IDLE, BODY, TRLR.
REQ-018 IDLE: accepted word without LASTWORD -> BODY; with LASTWORD -> TRLR; none -> IDLE.
REQ-019 BODY: accepted word with LASTWORD -> TRLR; else stay BODY.
REQ-020 TRLR: write trailer word, tag=1, unconditionally -> IDLE next cycle.
REQ-021 Trailer SHALL be {4'hE, errflag, ovflag, 2'b00, wc[7:0]}.
REQ-022 wc SHALL count accepted data words of the frame including the last word, saturate at 255, clear when trailer written.
REQ-023 errflag SHALL set on any accepted word of the frame with ERRLOAD=1; clear when trailer written.
REQ-024 ovflag SHALL set when any word of the open frame is dropped by REQ-026; clear when trailer written.
REQ-025 Data word SHALL be written same cycle as PUSH (IDLE/BODY) with tag=0.
REQ-026 Data write while AFULL SHALL drop the word, set OVFL and ovflag; wc not incremented; LASTWORD still forces TRLR.
REQ-027 Trailer write SHALL never be blocked; occupancy <=31 at TRLR guarantees space.
REQ-028 PUSH in TRLR SHALL be captured, with LASTWORD/ERRLOAD, into a 1-deep hold register.
REQ-029 Hold SHALL be written in the following IDLE cycle as the accepted word, taking priority; a coincident PUSH in that cycle SHALL refill hold.
REQ-030 PUSH while hold occupied and not draining this cycle SHALL drop the word and set OVFL.
REQ-031 RD_EN with EMPTY=0: DOUT loads head word next edge, DVALID=1 that cycle, read pointer advances; RD_EN with EMPTY=1 ignored, DVALID=0.
REQ-032 Same-cycle write and read SHALL leave occupancy unchanged; both operations complete.
REQ-033 NFRAMES SHALL increment on trailer write, decrement on pop of tag=1 word; both same cycle -> unchanged.
REQ-034 EMPTY, AFULL, FRAME_RDY SHALL be registered, reflecting occupancy after the current edge.
REQ-035 DOUT SHALL hold last value when no pop.

Reset
REQ-036 RST=1 SHALL immediately force: pointers/count 0, DOUT 16'h0000, DVALID 0, EMPTY 1, AFULL 0, NFRAMES 0, FRAME_RDY 0, OVFL 0, hold empty, wc/errflag/ovflag 0, state IDLE.
REQ-037 RST mid-frame SHALL discard partial frame and all stored words; no trailer emitted.
REQ-038 First PUSH after RST release SHALL be accepted on the first rising edge with RST=0.

Verification
REQ-039 3 PUSH DIN=0x0001,0x0002,0x0003(LASTWORD) -> FIFO 0x0001,0x0002,0x0003,0xE003; NFRAMES=1.
REQ-040 2-word frame, ERRLOAD on word 1 -> trailer 0xE802; NFRAMES 1 -> 0 after 3 pops, EMPTY=1.
REQ-041 35 PUSH no reads, LASTWORD on 35th -> 31 data stored, 4 dropped, trailer 0xE41F, OVFL=1, count 32.
REQ-042 LASTWORD then PUSH 0x0055 in TRLR cycle -> trailer then 0x0055 written in next cycle; OVFL=0.
REQ-043 Continuous RD_EN with PUSH every cycle, frame length 8 -> occupancy never exceeds 2, DVALID words equal written order.
REQ-044 RST asserted after 5 words, no LASTWORD -> all outputs per REQ-036 within same cycle; next frame trailer wc counts from 1.
